y86_execute: RTL and testbench

//   Execute stage of the sequential (SEQ) Y86-64 processor. Computes val_e with the stage
//   ALU from the decoded icode/ifun and operands. Holds the condition-code register
//   (ZF/SF/OF) and produces the branch/conditional-move flag cnd. It sits between decode
//   (val_a/val_b) plus fetch (val_c) and the memory/write-back stages.

---
 rtl/y86_execute.sv | 122 ++++++++++++
 tb/tb_y86_execute.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/y86_execute.sv
// y86_execute: execute stage of the sequential Y86-64 processor.
//   Computes val_e with the stage ALU, keeps the condition-code register {ZF,SF,OF}
//   and derives cnd for jXX / cmovXX from the registered flags.
// Ports:
//   clock         rising-edge clock for the CC register
//   reset_n       asynchronous active-low reset (CC <= ZF=1,SF=0,OF=0)
//   in_code       icode
//   in_fun        ifun
//   val_a         operand A (rA)
//   val_b         operand B (rB / %rsp)
//   val_c         instruction constant
//   val_e         ALU result, combinational, forced to 0 during reset
//   cnd           condition result from the registered CC, forced to 0 during reset
//   cc_out[2:0]   {ZF,SF,OF} straight from the CC register (only with EXE_CC_OUT_EN)
// Configuration macro: EXE_CC_OUT_EN adds the cc_out port.
module y86_execute (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  in_code,
    input  logic [3:0]  in_fun,
    input  logic [63:0] val_a,
    input  logic [63:0] val_b,
    input  logic [63:0] val_c,
    output logic [63:0] val_e,
`ifdef EXE_CC_OUT_EN
    output logic        cnd,
    output logic [2:0]  cc_out
`else
    output logic        cnd
`endif
);

    localparam logic [3:0] IRrmovq = 4'h2;
    localparam logic [3:0] IIrmovq = 4'h3;
    localparam logic [3:0] IRmmovq = 4'h4;
    localparam logic [3:0] IMrmovq = 4'h5;
    localparam logic [3:0] IOpq    = 4'h6;
    localparam logic [3:0] IJxx    = 4'h7;
    localparam logic [3:0] ICall   = 4'h8;
    localparam logic [3:0] IRet    = 4'h9;
    localparam logic [3:0] IPushq  = 4'hA;
    localparam logic [3:0] IPopq   = 4'hB;

    localparam logic [63:0] StackStep = 64'd8;

    logic [63:0] alu_result;
    logic        cc_update;
    logic        zf_q, sf_q, of_q;
    logic        zf_d, sf_d, of_d;
    logic        cond;

    // Stage ALU; unlisted icodes and OPq with ifun>3 produce zero.
    always_comb begin
        alu_result = 64'd0;
        unique case (in_code)
            IRrmovq:          alu_result = val_a;
            IIrmovq:          alu_result = val_c;
            IRmmovq, IMrmovq: alu_result = val_b + val_c;
            IOpq: begin
                unique case (in_fun)
                    4'h0:    alu_result = val_b + val_a;
                    4'h1:    alu_result = val_b - val_a;
                    4'h2:    alu_result = val_b & val_a;
                    4'h3:    alu_result = val_b ^ val_a;
                    default: alu_result = 64'd0;
                endcase
            end
            ICall, IPushq:    alu_result = val_b - StackStep;
            IRet, IPopq:      alu_result = val_b + StackStep;
            default:          alu_result = 64'd0;
        endcase
    end

    assign cc_update = (in_code == IOpq) && (in_fun < 4'h4);

    // Next flags; only consumed when cc_update is set, so ifun>3 never reaches here.
    always_comb begin
        zf_d = (alu_result == 64'd0);
        sf_d = alu_result[63];
        of_d = 1'b0;
        if (in_fun == 4'h0) begin
            of_d = (val_a[63] == val_b[63]) && (alu_result[63] != val_a[63]);
        end else if (in_fun == 4'h1) begin
            of_d = (val_a[63] != val_b[63]) && (alu_result[63] != val_b[63]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (cc_update) begin
            zf_q <= zf_d;
            sf_q <= sf_d;
            of_q <= of_d;
        end
    end

    // Condition evaluated from the registered flags only, so an OPq never sees its own.
    always_comb begin
        cond = 1'b0;
        unique case (in_fun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf_q ^ of_q) | zf_q;
            4'h2:    cond = sf_q ^ of_q;
            4'h3:    cond = zf_q;
            4'h4:    cond = ~zf_q;
            4'h5:    cond = ~(sf_q ^ of_q);
            4'h6:    cond = ~(sf_q ^ of_q) & ~zf_q;
            default: cond = 1'b0;
        endcase
    end

    assign val_e = reset_n ? alu_result : 64'd0;
    assign cnd   = reset_n && ((in_code == IRrmovq) || (in_code == IJxx)) && cond;

`ifdef EXE_CC_OUT_EN
    assign cc_out = {zf_q, sf_q, of_q};
`endif

endmodule

// File: tb/tb_y86_execute.sv
// tb_y86_execute: directed self-checking bench for y86_execute.
//   Inputs change on the falling edge; combinational outputs are sampled 1 time unit later.
//   Each step parks in_code at nop first so no unintended rising edge updates the CC.
module tb_y86_execute;

    logic        clock;
    logic        reset_n;
    logic [3:0]  in_code;
    logic [3:0]  in_fun;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
    logic [63:0] val_e;
    logic        cnd;
`ifdef EXE_CC_OUT_EN
    logic [2:0]  cc_out;
`endif

    int errors = 0;
    int checks = 0;

    y86_execute dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in_code (in_code),
        .in_fun  (in_fun),
        .val_a   (val_a),
        .val_b   (val_b),
        .val_c   (val_c),
        .val_e   (val_e),
`ifdef EXE_CC_OUT_EN
        .cnd     (cnd),
        .cc_out  (cc_out)
`else
        .cnd     (cnd)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply(input logic [3:0] code, input logic [3:0] fun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_code = 4'h1;
        @(negedge clock);
        in_code = code;
        in_fun  = fun;
        val_a   = a;
        val_b   = b;
        val_c   = c;
        #1;
    endtask

    // Let one rising edge pass with the current inputs held.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        in_code = 4'h1;
        in_fun  = 4'h0;
        val_a   = 64'd0;
        val_b   = 64'd0;
        val_c   = 64'd0;

        // Reset: outputs forced low.
        apply(4'h3, 4'h0, 64'd0, 64'd0, 64'd19);
        chk("rst_vale", val_e, 64'd0);
        apply(4'h7, 4'h0, 64'd0, 64'd0, 64'd0);
        chk("rst_cnd", {63'd0, cnd}, 64'd0);
`ifdef EXE_CC_OUT_EN
        chk("rst_cc", {61'd0, cc_out}, 64'd4);
`endif
        reset_n = 1'b1;
        apply(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        chk("rst_zf_e", {63'd0, cnd}, 64'd1);
        apply(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        chk("rst_ne", {63'd0, cnd}, 64'd0);

        // 1. mrmovq address, ifun ignored, CC untouched.
        apply(4'h5, 4'h4, 64'd10, 64'd41, 64'd23);
        chk("t1_vale", val_e, 64'd64);
        chk("t1_cnd", {63'd0, cnd}, 64'd0);
        tick();
        apply(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        chk("t1_cc_keep", {63'd0, cnd}, 64'd1);

        // 2. add 73+74.
        apply(4'h6, 4'h0, 64'd73, 64'd74, 64'd0);
        chk("t2_vale", val_e, 64'd147);
        chk("t2_opq_cnd", {63'd0, cnd}, 64'd0);
        tick();
        apply(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        chk("t2_e", {63'd0, cnd}, 64'd0);
        apply(4'h7, 4'h4, 64'd0, 64'd0, 64'd0);
        chk("t2_ne", {63'd0, cnd}, 64'd1);
        apply(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
        chk("t2_g", {63'd0, cnd}, 64'd1);
        apply(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
        chk("t2_bad_fun", {63'd0, cnd}, 64'd0);

        // 3. sub to zero, then sub going negative.
        apply(4'h6, 4'h1, 64'd5, 64'd5, 64'd0);
        chk("t3_vale0", val_e, 64'd0);
        tick();
        apply(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        chk("t3_e", {63'd0, cnd}, 64'd1);
        apply(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
        chk("t3_vale_neg", val_e, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        apply(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("t3_l", {63'd0, cnd}, 64'd1);
        apply(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
        chk("t3_le", {63'd0, cnd}, 64'd1);
        apply(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
        chk("t3_ge", {63'd0, cnd}, 64'd0);

        // 4. Signed overflow on add: SF=1, OF=1.
        apply(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        chk("t4_vale", val_e, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
`ifdef EXE_CC_OUT_EN
        chk("t4_cc", {61'd0, cc_out}, 64'd3);
`endif
        apply(4'h2, 4'h5, 64'h1234_5678_9ABC_DEF0, 64'd7, 64'd9);
        chk("t4_cmov_cnd", {63'd0, cnd}, 64'd1);
        chk("t4_cmov_vale", val_e, 64'h1234_5678_9ABC_DEF0);
        apply(4'h2, 4'h2, 64'd1, 64'd0, 64'd0);
        chk("t4_cmovl", {63'd0, cnd}, 64'd0);

        // Sub overflow: 0x8000.. - 1 -> 0x7FFF.., OF=1, SF=0 -> l true, ge false.
        apply(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        chk("sub_of_vale", val_e, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        apply(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("sub_of_l", {63'd0, cnd}, 64'd1);

        // 5. Stack arithmetic, irmovq, unused OPq ifun.
        apply(4'h8, 4'h0, 64'd0, 64'd100, 64'd0);
        chk("t5_call", val_e, 64'd92);
        apply(4'hA, 4'h0, 64'd0, 64'd100, 64'd0);
        chk("t5_push", val_e, 64'd92);
        apply(4'h9, 4'h0, 64'd0, 64'd100, 64'd0);
        chk("t5_ret", val_e, 64'd108);
        apply(4'hB, 4'h0, 64'd0, 64'd100, 64'd0);
        chk("t5_pop", val_e, 64'd108);
        apply(4'h3, 4'h0, 64'd0, 64'd100, 64'd19);
        chk("t5_irmov", val_e, 64'd19);
        apply(4'h6, 4'h4, 64'd5, 64'd100, 64'd0);
        chk("t5_opq_bad", val_e, 64'd0);
        tick();
        apply(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("t5_cc_keep", {63'd0, cnd}, 64'd1);

        // and/xor; OF cleared by logic ops.
        apply(4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0);
        chk("and_vale", val_e, 64'd0);
        tick();
        apply(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        chk("and_e", {63'd0, cnd}, 64'd1);
        apply(4'h6, 4'h3, 64'hFF, 64'h0F, 64'd0);
        chk("xor_vale", val_e, 64'hF0);
        tick();
        apply(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("xor_l", {63'd0, cnd}, 64'd0);

        // Zero-result icodes and cnd gating by icode.
        apply(4'hC, 4'h0, 64'd1, 64'd2, 64'd3);
        chk("illegal_vale", val_e, 64'd0);
        apply(4'h1, 4'h0, 64'd1, 64'd2, 64'd3);
        chk("nop_vale", val_e, 64'd0);
        apply(4'h7, 4'h0, 64'd1, 64'd2, 64'd3);
        chk("jmp_vale", val_e, 64'd0);
        chk("jmp_cnd", {63'd0, cnd}, 64'd1);
        apply(4'h5, 4'h0, 64'd1, 64'd2, 64'd3);
        chk("nonbr_cnd", {63'd0, cnd}, 64'd0);

        // 6. Mid-run reset after a sub that set SF.
        apply(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
        tick();
        apply(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("t6_pre_l", {63'd0, cnd}, 64'd1);
        apply(4'h3, 4'h0, 64'd0, 64'd0, 64'd19);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_vale", val_e, 64'd0);
`ifdef EXE_CC_OUT_EN
        chk("t6_rst_cc", {61'd0, cc_out}, 64'd4);
`endif
        in_code = 4'h7;
        in_fun  = 4'h0;
        #1;
        chk("t6_rst_cnd", {63'd0, cnd}, 64'd0);
        // Reset must dominate an edge presenting an updating OPq.
        apply(4'h6, 4'h1, 64'd1, 64'd0, 64'd0);
        tick();
        reset_n = 1'b1;
        apply(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
        chk("t6_post_e", {63'd0, cnd}, 64'd1);
        apply(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
        chk("t6_post_l", {63'd0, cnd}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
